// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between four requesting masters and the round-robin arbiter.
// The master side drives requests and release; the slave (arbiter) side returns the grant.
interface rr_arbiter_4_if;
  logic       en;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  modport master (
    output en,
    output req,
    output done,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  timeout
  );

  modport slave (
    input  en,
    input  req,
    input  done,
    output grant,
    output grant_idx,
    output grant_valid,
    output timeout
  );
endinterface

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with a registered one-hot grant, its 2-bit encoded index,
// and a hold-time limit that forcibly revokes a grant after MAX_HOLD cycles.
module rr_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input logic           clk,
  input logic           rst_n,
  rr_arbiter_4_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   hold_cnt_q;
  logic [1:0]         last_owner_q;
  logic [3:0]         grant_q;
  logic [1:0]         grant_idx_q;
  logic               grant_valid_q;
  logic               timeout_q;

  logic [1:0]         sel;
  logic               owner_req;
  logic               hold_expired;

  // First requester after the previous owner, wrapping 3 -> 0; the previous owner is
  // checked last so it is only re-granted when nobody else is asking.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_pick = 2'd0;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    sel          = rr_pick(bus.req, last_owner_q);
    owner_req    = bus.req[grant_idx_q];
    hold_expired = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      hold_cnt_q    <= '0;
      last_owner_q  <= 2'd3;
      grant_q       <= 4'b0000;
      grant_idx_q   <= 2'd0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.en && (bus.req != 4'b0000)) begin
            grant_q       <= 4'b0001 << sel;
            grant_idx_q   <= sel;
            grant_valid_q <= 1'b1;
            hold_cnt_q    <= '0;
            state_q       <= StGrant;
          end
        end
        StGrant: begin
          // Release priority: disable, withdrawal, done, then hold expiry.
          if (!bus.en || !owner_req || bus.done || hold_expired) begin
            timeout_q     <= bus.en && owner_req && !bus.done;
            last_owner_q  <= grant_idx_q;
            grant_q       <= 4'b0000;
            grant_idx_q   <= 2'd0;
            grant_valid_q <= 1'b0;
            hold_cnt_q    <= '0;
            state_q       <= StIdle;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = grant_idx_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.timeout     = timeout_q;

  a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
  a_valid_match:   assert property (@(posedge clk) disable iff (!rst_n)
                                    grant_valid_q == (grant_q != 4'b0000));
  a_idx_match:     assert property (@(posedge clk) disable iff (!rst_n)
                                    grant_q == (grant_valid_q ? (4'b0001 << grant_idx_q) : 4'b0000));

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: directed scenarios plus randomized traffic,
// all compared against a cycle-level behavioural model of ownership and held cycles.
module tb_rr_arbiter_4;
  localparam int unsigned MAX_HOLD = 16;
  localparam int unsigned CNT_W    = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  rr_arbiter_4_if bus ();

  rr_arbiter_4 #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: who owns the resource (-1 = nobody), how many cycles it has been visible,
  // who owned it last, and whether the last release was a hold-time expiry.
  int m_owner;
  int m_held;
  int m_last;
  bit m_to;

  function void model_reset();
    m_owner = -1;
    m_held  = 0;
    m_last  = 3;
    m_to    = 1'b0;
  endfunction

  function void model_step();
    bit found;
    int idx;
    m_to = 1'b0;
    if (m_owner < 0) begin
      if (bus.en && bus.req != 4'b0000) begin
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          idx = (m_last + k) % 4;
          if (!found && bus.req[idx]) begin
            found   = 1'b1;
            m_owner = idx;
            m_held  = 1;
          end
        end
      end
    end else if (!bus.en || !bus.req[m_owner] || bus.done) begin
      m_last  = m_owner;
      m_owner = -1;
    end else if (m_held == int'(MAX_HOLD)) begin
      m_to    = 1'b1;
      m_last  = m_owner;
      m_owner = -1;
    end else begin
      m_held++;
    end
  endfunction

  function logic [7:0] model_out();
    logic [3:0] g;
    logic [1:0] i;
    g = 4'b0000;
    i = 2'd0;
    if (m_owner >= 0) begin
      g = 4'b0001 << m_owner;
      i = 2'(m_owner);
    end
    return {g, i, (m_owner >= 0), m_to};
  endfunction

  function logic [7:0] dut_out();
    return {bus.grant, bus.grant_idx, bus.grant_valid, bus.timeout};
  endfunction

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.en   = 1'b0;
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    #1 rst_n = 1'b0;
    model_reset();
    #2;
    checks++;
    if (dut_out() !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b", dut_out(), 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (dut_out() !== model_out()) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: got %b want %b", c, dut_out(), model_out());
      end
    end
  endtask

  task automatic test_rotation();
    logic [3:0] seen[$];
    logic [3:0] want[5];
    want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus.en  = 1'b1;
    bus.req = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (dut_out() !== model_out()) begin
        errors++;
        $display("FAIL rotation cyc %0d: got %b want %b", c, dut_out(), model_out());
      end
      if (bus.grant_valid === 1'b1) seen.push_back(bus.grant);
      bus.done = (m_owner >= 0);
    end
    bus.done = 1'b0;
    for (int n = 0; n < 5; n++) begin
      checks++;
      if (n >= seen.size() || seen[n] !== want[n]) begin
        errors++;
        $display("FAIL rotation_order %0d: got %b want %b", n,
                 (n < seen.size()) ? seen[n] : 4'bxxxx, want[n]);
      end
    end
  endtask

  task automatic test_timeout();
    int held_cnt = 0;
    int to_cnt   = 0;
    bus.req  = 4'b0100;
    bus.done = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      step();
      checks++;
      if (dut_out() !== model_out()) begin
        errors++;
        $display("FAIL timeout cyc %0d: got %b want %b", c, dut_out(), model_out());
      end
      if (c <= 17 && bus.grant === 4'b0100 && bus.grant_idx === 2'b10) held_cnt++;
      if (bus.timeout === 1'b1) to_cnt++;
    end
    checks++;
    if (held_cnt != int'(MAX_HOLD)) begin
      errors++;
      $display("FAIL timeout_hold_len: got %0d want %0d", held_cnt, MAX_HOLD);
    end
    checks++;
    if (to_cnt != 1) begin
      errors++;
      $display("FAIL timeout_pulse_count: got %0d want 1", to_cnt);
    end
    checks++;
    if (bus.grant !== 4'b0100) begin
      errors++;
      $display("FAIL timeout_regrant: got %b want 0100", bus.grant);
    end
    bus.req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_withdraw();
    logic [3:0] req_seq[4];
    logic [5:0] want[4];
    req_seq = '{4'b0010, 4'b1111, 4'b1101, 4'b1101};
    want    = '{{4'b0010, 2'b01}, {4'b0010, 2'b01}, {4'b0000, 2'b00}, {4'b0100, 2'b10}};
    for (int c = 0; c < 4; c++) begin
      bus.req = req_seq[c];
      step();
      checks++;
      if ({bus.grant, bus.grant_idx} !== want[c] || dut_out() !== model_out()) begin
        errors++;
        $display("FAIL withdraw cyc %0d: got %b want %b (grant,idx %b)", c, dut_out(),
                 model_out(), want[c]);
      end
    end
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    bus.req  = 4'b0000;
    step();
  endtask

  task automatic test_enable();
    apply_reset();
    bus.en   = 1'b0;
    bus.req  = 4'b1111;
    bus.done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (bus.grant_valid !== 1'b0 || dut_out() !== model_out()) begin
        errors++;
        $display("FAIL enable_off cyc %0d: got %b want %b", c, dut_out(), model_out());
      end
    end
    bus.en = 1'b1;
    step();
    checks++;
    if (bus.grant !== 4'b0001 || dut_out() !== model_out()) begin
      errors++;
      $display("FAIL enable_on: got %b want %b", dut_out(), model_out());
    end
    step();
    bus.en = 1'b0;
    step();
    checks++;
    if (dut_out() !== 8'h00) begin
      errors++;
      $display("FAIL enable_revoke: got %b want %b", dut_out(), 8'h00);
    end
  endtask

  task automatic test_reset_mid_grant();
    bus.en  = 1'b1;
    bus.req = 4'b1000;
    step();
    checks++;
    if (bus.grant !== 4'b1000 || dut_out() !== model_out()) begin
      errors++;
      $display("FAIL midrst_grant: got %b want %b", dut_out(), model_out());
    end
    step();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_out() !== 8'h00) begin
      errors++;
      $display("FAIL midrst_async_clear: got %b want %b", dut_out(), 8'h00);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    bus.req = 4'b1111;
    step();
    checks++;
    if (bus.grant !== 4'b0001 || dut_out() !== model_out()) begin
      errors++;
      $display("FAIL midrst_first_grant: got %b want %b", dut_out(), model_out());
    end
  endtask

  task automatic test_done_at_timeout();
    int guard = 0;
    bus.done = 1'b0;
    while (m_held < int'(MAX_HOLD) && m_owner >= 0 && guard < 40) begin
      step();
      guard++;
      checks++;
      if (dut_out() !== model_out()) begin
        errors++;
        $display("FAIL done_tmo_hold cyc %0d: got %b want %b", guard, dut_out(), model_out());
      end
    end
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    checks++;
    if (bus.grant_valid !== 1'b0 || bus.timeout !== 1'b0 || dut_out() !== model_out()) begin
      errors++;
      $display("FAIL done_tmo_release: got %b want %b", dut_out(), model_out());
    end
  endtask

  task automatic test_random();
    bus.req = 4'b0000;
    for (int c = 0; c < 600; c++) begin
      bus.en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 7) == 0) bus.req = 4'($urandom);
      bus.done = ($urandom_range(0, 19) == 0);
      step();
      checks++;
      if (dut_out() !== model_out()) begin
        errors++;
        $display("FAIL random cyc %0d: got %b want %b", c, dut_out(), model_out());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rotation();
    test_timeout();
    test_withdraw();
    test_enable();
    test_reset_mid_grant();
    test_done_at_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Round-robin arbiter sharing one 4-input resource (e.g. the 4-to-2 encoded select path) among four requesters.
- Issues a registered one-hot grant and its 2-bit encoded index, using the same encoding as the 4-to-2 encoder: one-hot 0001/0010/0100/1000 maps to 00/01/10/11.
- Enforces a maximum hold time so no requester can starve the others.
- Sits between the requesting masters and the shared resource's select input.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles one owner may hold the grant. Legal range 2..255.
- CNT_W, 8: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  arbiter enable. When 0, no new grants are issued and any current grant is revoked.
- req  input  4  request vector, one bit per requester. Level-sensitive; a requester holds its bit high until it is served.
- done  input  1  owner releases the resource. Sampled only in GRANT state.
- grant  output  4  registered one-hot grant; 0000 when no grant is active.
- grant_idx  output  2  encoded index of grant; 00 when grant_valid=0.
- grant_valid  output  1  high while a grant is active.
- timeout  output  1  single-cycle pulse, asserted when a grant is revoked by MAX_HOLD expiry.

Behaviour:
- Reset (async, rst_n=0):
  - grant=0000, grant_idx=00, grant_valid=0, timeout=0.
  - State=IDLE, hold_cnt=0, last_owner=3, so requester 0 has top priority after reset.
  - Deassertion of reset is synchronised by the usual flop release; the first arbitration happens on the first rising edge after release.
- All outputs are registered; there is no combinational path from inputs to outputs.
- FSM has two states: IDLE and GRANT.
- IDLE:
  - If en=1 and req!=0: select the first set bit of req, scanning from last_owner+1 upward with wrap 3->0.
  - At that same edge: grant=onehot(sel), grant_idx=sel, grant_valid=1, hold_cnt=0, state->GRANT.
  - Latency: req sampled at edge N gives grant visible after edge N (1 cycle).
  - Otherwise remain in IDLE with all outputs at their reset values.
- GRANT: hold_cnt increments every cycle. Release conditions, checked in priority order:
  1. en=0.
  2. req[owner]=0, i.e. the requester withdrew its request.
  3. done=1.
  4. hold_cnt==MAX_HOLD-1. This is a timeout: also set timeout=1 for exactly 1 cycle.
- On release, at the same edge:
  - grant=0000, grant_idx=00, grant_valid=0, last_owner=owner, hold_cnt=0, state->IDLE.
- Result: the grant is active for at most MAX_HOLD cycles, and there is always at least one idle cycle between consecutive grants (a bus-turnaround gap).
- Changes to req bits other than the owner's during GRANT are ignored until the next IDLE evaluation.
- If done=1 and timeout occur on the same edge, done takes priority: release happens but timeout stays 0.
- If only the previous owner is requesting, it is re-granted after the idle gap; round-robin only skips an owner when others are requesting.
- Reset asserted mid-grant: outputs clear immediately (asynchronously) and the pointer returns to last_owner=3.
- Invariants:
  - grant is always one-hot or zero.
  - grant_idx always equals the encoding of grant.
  - grant_valid equals (grant!=0).

Test Plan:
- Reset, then en=1 and req=1111 held high with done pulsed 1 cycle after each grant: grants rotate 0001, 0010, 0100, 1000, 0001 with grant_idx 00, 01, 10, 11, 00, and one grant_valid=0 cycle between grants.
- req=0100 only, done never asserted, MAX_HOLD=16: grant=0100 and grant_idx=10 for exactly 16 cycles; timeout=1 for 1 cycle at release; 1 idle cycle; then re-granted 0100.
- Owner 1 holding (grant=0010), req=1111, then req[1] dropped: grant drops to 0000 at the next edge; next grant is 0100 (idx 10), not 0001.
- en=0 with req=1111: grant_valid stays 0. Then en=1: after 1 cycle grant=0001. Then en=0 mid-grant: grant=0000 at the next edge with timeout=0.
- Assert rst_n=0 mid-grant with grant=1000: all outputs go to 0 without waiting for a clock edge; after release with req=1111, the first grant is 0001.
- done=1 on the same cycle hold_cnt reaches MAX_HOLD-1: release occurs and timeout remains 0.
